// File: rtl/toggle_pkg.sv
// Shared types and defaults for the pushbutton-to-toggle-pulse front end.
package toggle_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1000;
    localparam int DEF_REPEAT_CYCLES   = 50000;

endpackage

// File: rtl/btn_sync.sv
// Multi-flop synchroniser bringing the raw button level into the clk domain.
module btn_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) chain <= '0;
        else       chain <= {chain[SYNC_STAGES-2:0], d};
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/toggle_debounce.sv
// Debounces a bouncy pushbutton and emits single-cycle t pulses,
// with optional auto-repeat while held and a running pulse count.
module toggle_debounce
    import toggle_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           = 16,
    parameter int PCNT_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_in,
    input  logic              enable,
    input  logic              repeat_en,
    output logic              t,
    output logic              btn_stable,
    output logic [PCNT_W-1:0] pulse_cnt
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] rpt_cnt, rpt_n;
    logic             btn_s;
    logic             stable_n;
    logic             fire;

    btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rpt_cnt <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rpt_cnt <= rpt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rpt_n    = rpt_cnt;
        stable_n = btn_stable;
        fire     = 1'b0;
        unique case (state)
            IDLE: begin
                stable_n = 1'b0;
                if (btn_s) begin
                    state_n = DEB_PRESS;
                    cnt_n   = '0;
                end
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_n = IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_n  = PRESSED;
                    stable_n = 1'b1;
                    rpt_n    = '0;
                    fire     = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_n = DEB_RELEASE;
                    cnt_n   = '0;
                end else if (!repeat_en) begin
                    rpt_n = '0;
                end else if (rpt_cnt == RPT_LAST) begin
                    fire  = 1'b1;
                    rpt_n = '0;
                end else begin
                    rpt_n = rpt_cnt + 1'b1;
                end
            end
            DEB_RELEASE: begin
                // A bounce back high returns to the held state silently.
                if (btn_s) begin
                    state_n = PRESSED;
                    rpt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n  = IDLE;
                    stable_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t          <= 1'b0;
            btn_stable <= 1'b0;
            pulse_cnt  <= '0;
        end else begin
            t          <= fire & enable;
            btn_stable <= stable_n;
            if (fire && enable) pulse_cnt <= pulse_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_toggle_debounce.sv
// Directed bench for toggle_debounce with a run-length reference model.
module tb_toggle_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int REP  = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_in = 1'b0;
    logic       enable = 1'b1;
    logic       repeat_en = 1'b0;
    logic       t;
    logic       btn_stable;
    logic [7:0] pulse_cnt;

    int checks = 0;
    int failures = 0;
    bit run_chk = 1'b0;

    // Reference: synced level is btn_in delayed SYNC edges; a level change
    // is accepted after DEB+1 consecutive differing samples.
    logic [SYNC-1:0] m_pipe;
    logic            m_stable;
    int              m_run;
    int              m_ticks;
    logic            m_t;
    logic [7:0]      m_cnt;

    toggle_debounce #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_CYCLES   (REP),
        .CNT_W           (16),
        .PCNT_W          (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .enable     (enable),
        .repeat_en  (repeat_en),
        .t          (t),
        .btn_stable (btn_stable),
        .pulse_cnt  (pulse_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pipe   = '0;
        m_stable = 1'b0;
        m_run    = 0;
        m_ticks  = 0;
        m_t      = 1'b0;
        m_cnt    = '0;
    endtask

    task automatic model_step();
        logic s;
        logic fire;
        s      = m_pipe[SYNC-1];
        m_pipe = {m_pipe[SYNC-2:0], btn_in};
        fire   = 1'b0;
        if (s != m_stable) begin
            m_run++;
            if (m_run == DEB + 1) begin
                m_stable = s;
                m_run    = 0;
                if (s) begin
                    m_ticks = 0;
                    fire    = 1'b1;
                end
            end
        end else begin
            if (m_stable && m_run == 0) begin
                if (!repeat_en) begin
                    m_ticks = 0;
                end else begin
                    m_ticks++;
                    if (m_ticks == REP) begin
                        fire    = 1'b1;
                        m_ticks = 0;
                    end
                end
            end else if (m_stable) begin
                m_ticks = 0;
            end
            m_run = 0;
        end
        m_t = fire & enable;
        if (m_t) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else       model_step();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic async_reset_check(input string tag);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk({tag, "_t"}, t, 0);
        chk({tag, "_stable"}, btn_stable, 0);
        chk({tag, "_cnt"}, pulse_cnt, 0);
    endtask

    always @(negedge clk) begin
        if (run_chk) begin
            chk("model_t", t, m_t);
            chk("model_stable", btn_stable, m_stable);
            chk("model_cnt", pulse_cnt, m_cnt);
        end
    end

    initial begin
        logic [31:0] mask;
        int          npulse;
        model_reset();
        #1;
        chk("rst_t", t, 0);
        chk("rst_stable", btn_stable, 0);
        chk("rst_cnt", pulse_cnt, 0);
        run_chk = 1'b1;

        // clean press
        btn_in = 1'b1;
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk("s1_t", t, (e == 7) ? 1 : 0);
            chk("s1_stable", btn_stable, (e >= 7) ? 1 : 0);
        end
        chk("s1_cnt", pulse_cnt, 1);

        // release bounce
        btn_in = 1'b0;
        tick();
        tick();
        btn_in = 1'b1;
        tick();
        btn_in = 1'b0;
        for (int e = 4; e <= 12; e++) begin
            tick();
            if (e == 9)  chk("s3_stable_hold", btn_stable, 1);
            if (e == 10) chk("s3_stable_fall", btn_stable, 0);
        end
        chk("s3_cnt", pulse_cnt, 1);

        // glitch
        btn_in = 1'b0;
        do_reset();
        btn_in = 1'b1;
        run(3);
        btn_in = 1'b0;
        run(12);
        chk("s2_stable", btn_stable, 0);
        chk("s2_cnt", pulse_cnt, 0);

        // auto-repeat
        repeat_en = 1'b1;
        btn_in = 1'b1;
        do_reset();
        mask = '0;
        for (int e = 1; e <= 25; e++) begin
            tick();
            if (t) mask[e] = 1'b1;
        end
        chk("s4_edges", mask, (32'd1 << 7) | (32'd1 << 13) |
                              (32'd1 << 19) | (32'd1 << 25));
        chk("s4_cnt", pulse_cnt, 4);

        // disabled press and release
        btn_in = 1'b0;
        run(10);
        enable = 1'b0;
        repeat_en = 1'b0;
        btn_in = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 7) chk("s5_stable_rise", btn_stable, 1);
        end
        btn_in = 1'b0;
        run(10);
        chk("s5_stable_fall", btn_stable, 0);
        chk("s5_cnt", pulse_cnt, 4);
        enable = 1'b1;

        // reset mid-DEB_PRESS and mid-PRESSED
        btn_in = 1'b1;
        do_reset();
        run(4);
        async_reset_check("s6_deb");
        do_reset();
        run(8);
        chk("s6_pre_cnt", pulse_cnt, 1);
        async_reset_check("s6_prs");
        do_reset();
        npulse = 0;
        for (int e = 1; e <= 15; e++) begin
            tick();
            if (t) npulse++;
            if (e == 7) chk("s6_rel_t", t, 1);
        end
        chk("s6_rel_pulses", npulse, 1);

        // wrap
        repeat_en = 1'b1;
        do_reset();
        run(7 + 6 * 254);
        chk("s6_cnt255", pulse_cnt, 255);
        run(6);
        chk("s6_wrap_t", t, 1);
        chk("s6_wrap_cnt", pulse_cnt, 0);

        btn_in = 1'b0;
        run(12);
        @(negedge clk);
        run_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/toggle_debounce.md
Name: toggle_debounce

Overview:
- Upstream stage for the T flip-flop built from a D flip-flop: turns a raw, bouncy, asynchronous pushbutton into clean single-cycle `t` toggle pulses.
- Chain: synchroniser → debounce FSM → pulse generator, with optional auto-repeat while the button is held.
- Also keeps a count of emitted pulses for status and checking.
- Output `t` feeds the T flip-flop's `t` input directly, on the same `clk`.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on btn_in (≥2).
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles needed to accept a press or release (≥2).
- REPEAT_CYCLES, 50000, auto-repeat period in cycles while held (≥2).
- CNT_W, 16, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES)-1.
- PCNT_W, 8, width of pulse_cnt.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw asynchronous button level.
- enable  input  1  1 = emit t pulses; 0 = FSM still tracks the button but t is suppressed.
- repeat_en  input  1  1 = auto-repeat while held.
- t  output  1  registered one-cycle toggle pulse.
- btn_stable  output  1  registered debounced button level.
- pulse_cnt  output  PCNT_W  number of t pulses emitted; wraps modulo 2^PCNT_W.

Behaviour:
- Reset: async assert clears sync chain, state, counters, t, btn_stable and pulse_cnt to 0 immediately. State goes to IDLE.
- Synchroniser: btn_s is the last of SYNC_STAGES flops. Its reset value is 0.
- FSM states: IDLE, DEB_PRESS, PRESSED, DEB_RELEASE.
- IDLE:
  - btn_stable=0.
  - btn_s=1 → DEB_PRESS with cnt=0.
- DEB_PRESS:
  - btn_s=0 → IDLE (glitch rejected; no pulse).
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1 → PRESSED: set btn_stable=1 and rpt_cnt=0, and pulse t for 1 cycle if enable.
  - Otherwise cnt++.
- PRESSED:
  - btn_s=0 → DEB_RELEASE with cnt=0. rpt_cnt holds.
  - Otherwise, if repeat_en: when rpt_cnt==REPEAT_CYCLES-1, pulse t (if enable) and set rpt_cnt=0; else rpt_cnt++.
  - If repeat_en=0: rpt_cnt is held at 0.
- DEB_RELEASE:
  - btn_s=1 → PRESSED with rpt_cnt=0. No pulse; btn_stable stays 1.
  - Otherwise, if cnt==DEBOUNCE_CYCLES-1 → IDLE with btn_stable=0.
  - Otherwise cnt++.
- Latency: with btn_in held high from before edge 1, t is high for the single cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES+1. btn_stable rises on that same edge.
- Pulse width: t is never high for two consecutive cycles.
- Auto-repeat spacing: repeat pulses are exactly REPEAT_CYCLES cycles apart, the first one REPEAT_CYCLES after the press pulse.
- pulse_cnt increments on exactly the edges that set t=1. It wraps from 2^PCNT_W-1 to 0.
- enable=0 blocks both t and pulse_cnt; enable is sampled on the edge that would emit.
- repeat_en deasserted mid-hold resets rpt_cnt to 0. On reassertion the full REPEAT_CYCLES period applies again.
- Reset released while btn_in is high: the full sync + debounce sequence runs again. Exactly one press pulse, no spurious pulse at reset release.

Decomposition:
- Package toggle_pkg:
  - state enum: IDLE=2'd0, DEB_PRESS=2'd1, PRESSED=2'd2, DEB_RELEASE=2'd3;
  - default constants for DEBOUNCE_CYCLES and REPEAT_CYCLES.
- Sub-module btn_sync: parameterised SYNC_STAGES flop chain with async active-high reset, ports clk, reset, d, q.
- The FSM, counters and pulse register stay in toggle_debounce.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=6, PCNT_W=8, enable=1 unless stated):
1. Clean press: btn_in=1 from before edge 1, held 10 cycles, repeat_en=0 → t high only after edge 7; btn_stable=1 from edge 7; pulse_cnt=1.
2. Glitch: btn_in high for 3 cycles then low → t never asserts, btn_stable stays 0, pulse_cnt=0.
3. Release bounce: after scenario 1, btn_in 0 for 2 cycles, 1 for 1, then 0 → btn_stable stays 1 until 4 consecutive synced-low cycles; no extra t.
4. Auto-repeat: repeat_en=1, hold 25 cycles → t after edges 7, 13, 19, 25; pulse_cnt=4.
5. enable=0 press and release → btn_stable rises and falls normally; t stays 0; pulse_cnt unchanged.
6. Reset and wrap:
   - Reset asserted mid-DEB_PRESS and again mid-PRESSED → all outputs 0 immediately.
   - After reset release with btn_in held high → exactly one t at 7 edges after release.
   - Preload 255 pulses, emit one more → pulse_cnt=0.
